// File: rtl/yarp_imem_responder_if.sv
// Fetch-side bus between the YARP core (master) and the instruction memory responder (slave).
// Requests carry no ready: every cycle with instr_mem_req_i=1 is a fetch the memory must take.
// Each accepted fetch returns exactly one response, in request order.
// mem_rd_valid_o marks that response; mem_rd_err_o and mem_rd_data_o are meaningful only with it.
interface yarp_imem_responder_if;
    logic        instr_mem_req_i;
    logic [31:0] instr_mem_addr_i;
    logic [31:0] mem_rd_data_o;
    logic        mem_rd_valid_o;
    logic        mem_rd_err_o;

    modport master (
        output instr_mem_req_i,
        output instr_mem_addr_i,
        input  mem_rd_data_o,
        input  mem_rd_valid_o,
        input  mem_rd_err_o
    );

    modport slave (
        input  instr_mem_req_i,
        input  instr_mem_addr_i,
        output mem_rd_data_o,
        output mem_rd_valid_o,
        output mem_rd_err_o
    );
endinterface

// File: rtl/yarp_imem_responder.sv
// Instruction memory responder: fixed-latency, fully pipelined word reads with error responses
// for misaligned or out-of-range fetches, plus a preload port that works through reset.
module yarp_imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned RD_LATENCY  = 1,
    parameter logic [31:0] ERR_DATA    = 32'h0000_0013
) (
    input  logic                        clk,
    input  logic                        reset_n,
    yarp_imem_responder_if.slave        fetch,
    input  logic                        load_we_i,
    input  logic [31:0]                 load_addr_i,
    input  logic [31:0]                 load_data_i,
    output logic [31:0]                 rd_count_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // Decode shared by fetch and load: offset wraps at 32 bits, so addresses below the
    // base are rejected explicitly rather than relying on the wrapped index.
    logic [31:0]      fetch_off;
    logic             fetch_err;
    logic [IDX_W-1:0] fetch_idx;
    logic [31:0]      load_off;
    logic             load_err;
    logic [IDX_W-1:0] load_idx;

    assign fetch_off = fetch.instr_mem_addr_i - BASE_ADDR;
    assign fetch_idx = fetch_off[IDX_W+1:2];
    assign fetch_err = (fetch.instr_mem_addr_i < BASE_ADDR)
                    || ({2'b00, fetch_off[31:2]} >= DEPTH_WORDS)
                    || (fetch.instr_mem_addr_i[1:0] != 2'b00);

    assign load_off = load_addr_i - BASE_ADDR;
    assign load_idx = load_off[IDX_W+1:2];
    assign load_err = (load_addr_i < BASE_ADDR)
                   || ({2'b00, load_off[31:2]} >= DEPTH_WORDS)
                   || (load_addr_i[1:0] != 2'b00);

    // Word array: never reset, written only by the preload port (independent of reset_n).
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (load_we_i && !load_err) begin
            mem[load_idx] <= load_data_i;
        end
    end

    // Read pipeline. Stage 0 performs the synchronous array read, which sees the pre-edge
    // contents, so a same-edge load to the same word is returned as the old value.
    logic [RD_LATENCY-1:0] st_valid;
    logic [RD_LATENCY-1:0] st_err;
    logic [31:0]           st_data [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_valid <= '0;
            st_err   <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                st_data[i] <= '0;
            end
        end else begin
            st_valid[0] <= fetch.instr_mem_req_i;
            st_err[0]   <= fetch.instr_mem_req_i && fetch_err;
            if (fetch.instr_mem_req_i) begin
                st_data[0] <= fetch_err ? ERR_DATA : mem[fetch_idx];
            end
            // Data only advances with a valid entry, so the output word holds when idle.
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                st_valid[i] <= st_valid[i-1];
                st_err[i]   <= st_err[i-1];
                if (st_valid[i-1]) begin
                    st_data[i] <= st_data[i-1];
                end
            end
        end
    end

    assign fetch.mem_rd_valid_o = st_valid[RD_LATENCY-1];
    assign fetch.mem_rd_err_o   = st_err[RD_LATENCY-1];
    assign fetch.mem_rd_data_o  = st_data[RD_LATENCY-1];

    // Accepted-fetch counter, errors included; wraps naturally.
    logic [31:0] rd_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_count_q <= '0;
        end else if (fetch.instr_mem_req_i) begin
            rd_count_q <= rd_count_q + 32'd1;
        end
    end

    assign rd_count_o = rd_count_q;
endmodule

// File: tb/tb_yarp_imem_responder.sv
// Bench for yarp_imem_responder: five instances (latency 1..4, plus a high BASE_ADDR one)
// share one stimulus stream and are checked every cycle against a queue-based model.
module tb_yarp_imem_responder;
  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [31:0] addr;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  yarp_imem_responder_if if_l1 ();
  yarp_imem_responder_if if_l2 ();
  yarp_imem_responder_if if_l3 ();
  yarp_imem_responder_if if_l4 ();
  yarp_imem_responder_if if_b8 ();

  assign if_l1.instr_mem_req_i = req;  assign if_l1.instr_mem_addr_i = addr;
  assign if_l2.instr_mem_req_i = req;  assign if_l2.instr_mem_addr_i = addr;
  assign if_l3.instr_mem_req_i = req;  assign if_l3.instr_mem_addr_i = addr;
  assign if_l4.instr_mem_req_i = req;  assign if_l4.instr_mem_addr_i = addr;
  assign if_b8.instr_mem_req_i = req;  assign if_b8.instr_mem_addr_i = addr;

  logic [31:0] cnt [NI];

  yarp_imem_responder #(.RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .fetch(if_l1.slave), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .rd_count_o(cnt[0]));
  yarp_imem_responder #(.RD_LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .fetch(if_l2.slave), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .rd_count_o(cnt[1]));
  yarp_imem_responder #(.RD_LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .fetch(if_l3.slave), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .rd_count_o(cnt[2]));
  yarp_imem_responder #(.RD_LATENCY(4)) u_l4 (
    .clk(clk), .reset_n(reset_n), .fetch(if_l4.slave), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .rd_count_o(cnt[3]));
  yarp_imem_responder #(.RD_LATENCY(1), .BASE_ADDR(32'h8000_0000)) u_b8 (
    .clk(clk), .reset_n(reset_n), .fetch(if_b8.slave), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .rd_count_o(cnt[4]));

  logic        dut_v [NI];
  logic        dut_e [NI];
  logic [31:0] dut_d [NI];
  assign dut_v[0] = if_l1.mem_rd_valid_o; assign dut_e[0] = if_l1.mem_rd_err_o; assign dut_d[0] = if_l1.mem_rd_data_o;
  assign dut_v[1] = if_l2.mem_rd_valid_o; assign dut_e[1] = if_l2.mem_rd_err_o; assign dut_d[1] = if_l2.mem_rd_data_o;
  assign dut_v[2] = if_l3.mem_rd_valid_o; assign dut_e[2] = if_l3.mem_rd_err_o; assign dut_d[2] = if_l3.mem_rd_data_o;
  assign dut_v[3] = if_l4.mem_rd_valid_o; assign dut_e[3] = if_l4.mem_rd_err_o; assign dut_d[3] = if_l4.mem_rd_data_o;
  assign dut_v[4] = if_b8.mem_rd_valid_o; assign dut_e[4] = if_b8.mem_rd_err_o; assign dut_d[4] = if_b8.mem_rd_data_o;

  // ---------------- model ----------------
  function automatic int lat_of(input int k);
    return (k == 4) ? 1 : k + 1;
  endfunction

  function automatic longint base_of(input int k);
    return (k == 4) ? 64'h8000_0000 : 64'h0;
  endfunction

  function automatic bit model_err(input int k, input logic [31:0] a);
    longint la;
    la = longint'(a);
    if (la < base_of(k)) return 1'b1;
    if ((la - base_of(k)) / 4 >= 1024) return 1'b1;
    return (la % 4) != 0;
  endfunction

  function automatic int model_idx(input int k, input logic [31:0] a);
    return int'((longint'(a) - base_of(k)) / 4);
  endfunction

  function automatic logic [31:0] pre_word(input int i);
    if (i == 0) return 32'h0000_0093;
    if (i == 1) return 32'h0010_0113;
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  logic [31:0] mm [NI][1024];
  logic [64:0] exp_q [NI][$];   // {due_edge[31:0], err, data}
  logic [31:0] m_count [NI];
  logic [31:0] m_last [NI];
  int          edge_n = 0;

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < NI; k++) begin
      if (!reset_n) begin
        exp_q[k].delete();
        m_count[k] = 32'd0;
        m_last[k]  = 32'd0;
      end else if (req) begin
        logic        e;
        logic [31:0] d;
        e = model_err(k, addr);
        d = e ? 32'h0000_0013 : mm[k][model_idx(k, addr)];
        exp_q[k].push_back({32'(edge_n + lat_of(k) - 1), e, d});
        m_count[k] = m_count[k] + 32'd1;
      end
      if (load_we && !model_err(k, load_addr)) mm[k][model_idx(k, load_addr)] = load_data;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (edge_n > 0) begin
      for (int k = 0; k < NI; k++) begin
        logic        ev;
        logic        ee;
        logic [64:0] ent;
        ev = 1'b0;
        ee = 1'b0;
        if (exp_q[k].size() > 0) begin
          ent = exp_q[k][0];
          if (ent[64:33] == 32'(edge_n)) begin
            ev = 1'b1;
            ee = ent[32];
            m_last[k] = ent[31:0];
            void'(exp_q[k].pop_front());
          end
        end
        check($sformatf("u%0d.valid@%0d", k, edge_n), 32'(dut_v[k]), 32'(ev));
        check($sformatf("u%0d.err@%0d", k, edge_n), 32'(dut_e[k]), 32'(ee));
        check($sformatf("u%0d.data@%0d", k, edge_n), dut_d[k], m_last[k]);
        check($sformatf("u%0d.count@%0d", k, edge_n), cnt[k], m_count[k]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic fetch_req(input logic r, input logic [31:0] a);
    req  = r;
    addr = a;
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; addr = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    step();

    // preload while held in reset
    for (int i = 0; i < 8; i++) begin
      load_we = 1'b1; load_addr = 32'(4 * i); load_data = pre_word(i);
      step();
    end
    load_addr = 32'h20;        load_data = 32'hAAAA_AAAA; step();
    load_addr = 32'h8000_0000; load_data = 32'h1234_5678; step();
    check("reset.l1_valid", 32'(if_l1.mem_rd_valid_o), 32'd0);
    check("reset.l1_count", cnt[0], 32'd0);
    load_we = 1'b0; reset_n = 1'b1;
    step();

    // back-to-back fetches of the preloaded words
    fetch_req(1'b1, 32'h0); step();
    check("t1.valid0", 32'(if_l1.mem_rd_valid_o), 32'd1);
    check("t1.data0", if_l1.mem_rd_data_o, 32'h0000_0093);
    fetch_req(1'b1, 32'h4); step();
    check("t1.valid1", 32'(if_l1.mem_rd_valid_o), 32'd1);
    check("t1.data1", if_l1.mem_rd_data_o, 32'h0010_0113);
    check("t1.count", cnt[0], 32'd2);
    fetch_req(1'b0, 32'h0); step();
    check("t1.idle_valid", 32'(if_l1.mem_rd_valid_o), 32'd0);
    check("t1.hold_data", if_l1.mem_rd_data_o, 32'h0010_0113);

    // misaligned, out of range, dropped bad load
    fetch_req(1'b1, 32'h2); step();
    check("t2.mis_err", 32'(if_l1.mem_rd_err_o), 32'd1);
    check("t2.mis_data", if_l1.mem_rd_data_o, 32'h0000_0013);
    fetch_req(1'b1, 32'h1000); step();
    check("t2.oor_err", 32'(if_l1.mem_rd_err_o), 32'd1);
    check("t2.oor_data", if_l1.mem_rd_data_o, 32'h0000_0013);
    fetch_req(1'b0, 32'h0);
    load_we = 1'b1; load_addr = 32'h1000; load_data = 32'hDEAD_BEEF; step();
    check("t2.idle_err", 32'(if_l1.mem_rd_err_o), 32'd0);
    load_we = 1'b0;
    fetch_req(1'b1, 32'h0); step();
    check("t2.reread", if_l1.mem_rd_data_o, 32'h0000_0093);
    fetch_req(1'b0, 32'h0);
    repeat (4) step();

    // latency sweep: 8 contiguous fetches
    for (int i = 0; i < 12; i++) begin
      fetch_req(i < 8, 32'(4 * (i % 8)));
      step();
      check($sformatf("t3.l4_valid%0d", i), 32'(if_l4.mem_rd_valid_o), 32'(i >= 3 && i <= 10));
      check($sformatf("t3.l2_valid%0d", i), 32'(if_l2.mem_rd_valid_o), 32'(i >= 1 && i <= 8));
      if (i == 3) check("t3.l4_first", if_l4.mem_rd_data_o, 32'h0000_0093);
    end
    fetch_req(1'b0, 32'h0);
    step();

    // same-edge read and load of one word
    fetch_req(1'b1, 32'h20);
    load_we = 1'b1; load_addr = 32'h20; load_data = 32'h5555_5555;
    step();
    check("t4.old", if_l1.mem_rd_data_o, 32'hAAAA_AAAA);
    load_we = 1'b0;
    step();
    check("t4.new", if_l1.mem_rd_data_o, 32'h5555_5555);
    fetch_req(1'b0, 32'h0);
    repeat (4) step();

    // reset with fetches in flight; req during reset ignored
    fetch_req(1'b1, 32'h0); step();
    fetch_req(1'b1, 32'h4); step();
    fetch_req(1'b1, 32'h8); reset_n = 1'b0; step();
    check("t5.l3_valid", 32'(if_l3.mem_rd_valid_o), 32'd0);
    check("t5.l3_data", if_l3.mem_rd_data_o, 32'd0);
    check("t5.l3_count", cnt[2], 32'd0);
    check("t5.l1_data", if_l1.mem_rd_data_o, 32'd0);
    fetch_req(1'b0, 32'h0); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5.l3_quiet%0d", i), 32'(if_l3.mem_rd_valid_o), 32'd0);
    end

    // counter wrap and high base address
    u_l1.rd_count_q = 32'hFFFF_FFFF;
    u_l2.rd_count_q = 32'hFFFF_FFFF;
    u_l3.rd_count_q = 32'hFFFF_FFFF;
    u_l4.rd_count_q = 32'hFFFF_FFFF;
    u_b8.rd_count_q = 32'hFFFF_FFFF;
    for (int k = 0; k < NI; k++) m_count[k] = 32'hFFFF_FFFF;
    fetch_req(1'b1, 32'h0); step();
    check("t6.wrap", cnt[0], 32'd0);
    fetch_req(1'b1, 32'h7FFF_FFFC); step();
    check("t6.b8_below_err", 32'(if_b8.mem_rd_err_o), 32'd1);
    check("t6.b8_below_data", if_b8.mem_rd_data_o, 32'h0000_0013);
    fetch_req(1'b1, 32'h8000_0000); step();
    check("t6.b8_base_err", 32'(if_b8.mem_rd_err_o), 32'd0);
    check("t6.b8_base_data", if_b8.mem_rd_data_o, 32'h1234_5678);
    check("t6.l1_high_err", 32'(if_l1.mem_rd_err_o), 32'd1);
    fetch_req(1'b0, 32'h0);
    repeat (6) step();

    for (int k = 0; k < NI; k++) check($sformatf("drain.u%0d", k), 32'(exp_q[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
